// File: rtl/lcd_sequencer.sv
// lcd_sequencer: owns HD44780 bus timing. Runs the power-up init sequence
// (0x38, 0x0C, 0x06, 0x01), then sends single command/data bytes accepted
// over a valid/ready handshake. Each byte gets setup, enable pulse and wait.
module lcd_sequencer #(
   parameter int unsigned POWERUP_CYCLES    = 750000,
   parameter int unsigned SETUP_CYCLES      = 2,
   parameter int unsigned PULSE_CYCLES      = 25,
   parameter int unsigned CMD_WAIT_CYCLES   = 2500,
   parameter int unsigned CLEAR_WAIT_CYCLES = 82000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_valid,
   input  logic       req_rs,
   input  logic [7:0] req_data,
   output logic       req_ready,
   output logic       init_done,
   output logic       busy,
   output logic [7:0] lcd_data_bus,
   output logic       lcd_rs,
   output logic       lcd_rw,
   output logic       lcd_e
);

   localparam int unsigned CNT_W = 20;

   // Timed states load N-1 and leave when the counter reaches zero.
   localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_WAIT_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_POWERUP,
      ST_INIT_SETUP,
      ST_INIT_PULSE,
      ST_INIT_WAIT,
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_WAIT
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       idx_q, idx_d;
   logic             init_done_q, init_done_d;
   logic             req_ready_q, req_ready_d;
   logic             busy_q, busy_d;
   logic [7:0]       data_q, data_d;
   logic             rs_q, rs_d;
   logic             e_q, e_d;
   logic [1:0]       idx_nxt;

   function automatic logic [7:0] init_byte(input logic [1:0] idx);
      case (idx)
         2'd0:    return 8'h38;
         2'd1:    return 8'h0C;
         2'd2:    return 8'h06;
         default: return 8'h01;
      endcase
   endfunction

   // Clear (0x01) and home (0x02/0x03) commands need the long execution wait.
   function automatic logic [CNT_W-1:0] wait_load(input logic rs, input logic [7:0] data);
      if (!rs && (data == 8'h01 || data == 8'h02 || data == 8'h03))
         return CLEAR_LD;
      return CMD_LD;
   endfunction

   assign idx_nxt = idx_q + 2'd1;

   // Next-state, counter and registered-output computation.
   always_comb begin
      state_d     = state_q;
      cnt_d       = (cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
      idx_d       = idx_q;
      init_done_d = init_done_q;
      data_d      = data_q;
      rs_d        = rs_q;

      case (state_q)
         // Power-up counts up from the reset value of zero; every other
         // timed state counts down from a loaded value.
         ST_POWERUP: begin
            if (cnt_q == PWR_LAST) begin
               state_d = ST_INIT_SETUP;
               cnt_d   = SETUP_LD;
               data_d  = init_byte(idx_q);
               rs_d    = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_INIT_SETUP: begin
            if (cnt_q == '0) begin
               state_d = ST_INIT_PULSE;
               cnt_d   = PULSE_LD;
            end
         end
         ST_INIT_PULSE: begin
            if (cnt_q == '0) begin
               state_d = ST_INIT_WAIT;
               cnt_d   = (idx_q == 2'd3) ? CLEAR_LD : CMD_LD;
            end
         end
         ST_INIT_WAIT: begin
            if (cnt_q == '0) begin
               if (idx_q == 2'd3) begin
                  init_done_d = 1'b1;
                  state_d     = ST_IDLE;
               end else begin
                  idx_d   = idx_nxt;
                  data_d  = init_byte(idx_nxt);
                  state_d = ST_INIT_SETUP;
                  cnt_d   = SETUP_LD;
               end
            end
         end
         ST_IDLE: begin
            if (req_valid && req_ready_q) begin
               data_d  = req_data;
               rs_d    = req_rs;
               state_d = ST_SETUP;
               cnt_d   = SETUP_LD;
            end
         end
         ST_SETUP: begin
            if (cnt_q == '0) begin
               state_d = ST_PULSE;
               cnt_d   = PULSE_LD;
            end
         end
         ST_PULSE: begin
            if (cnt_q == '0) begin
               state_d = ST_WAIT;
               cnt_d   = wait_load(rs_q, data_q);
            end
         end
         ST_WAIT: begin
            if (cnt_q == '0)
               state_d = ST_IDLE;
         end
         default: state_d = ST_POWERUP;
      endcase

      e_d    = (state_d == ST_INIT_PULSE) || (state_d == ST_PULSE);
      busy_d = (state_d != ST_IDLE);
      // Ready rises one cycle after IDLE is entered and drops on acceptance.
      req_ready_d = (state_q == ST_IDLE) && (state_d == ST_IDLE) && init_done_q;
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_POWERUP;
         cnt_q       <= '0;
         idx_q       <= '0;
         init_done_q <= 1'b0;
         req_ready_q <= 1'b0;
         busy_q      <= 1'b1;
         data_q      <= '0;
         rs_q        <= 1'b0;
         e_q         <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         init_done_q <= init_done_d;
         req_ready_q <= req_ready_d;
         busy_q      <= busy_d;
         data_q      <= data_d;
         rs_q        <= rs_d;
         e_q         <= e_d;
      end
   end

   assign req_ready    = req_ready_q;
   assign init_done    = init_done_q;
   assign busy         = busy_q;
   assign lcd_data_bus = data_q;
   assign lcd_rs       = rs_q;
   assign lcd_rw       = 1'b0;
   assign lcd_e        = e_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer with small timing parameters.
module tb_lcd_sequencer;

   localparam int P_PWR = 10;
   localparam int P_SET = 2;
   localparam int P_PUL = 3;
   localparam int P_CMD = 5;
   localparam int P_CLR = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic       req_valid;
   logic       req_rs;
   logic [7:0] req_data;
   logic       req_ready;
   logic       init_done;
   logic       busy;
   logic [7:0] lcd_data_bus;
   logic       lcd_rs;
   logic       lcd_rw;
   logic       lcd_e;

   int checks = 0;
   int errors = 0;
   int pulses = 0;
   int stab_viol = 0;
   int rw_viol = 0;
   logic       prev_e = 1'b0;
   logic [7:0] prev_bus = '0;
   logic       prev_rs = 1'b0;

   lcd_sequencer #(
      .POWERUP_CYCLES   (P_PWR),
      .SETUP_CYCLES     (P_SET),
      .PULSE_CYCLES     (P_PUL),
      .CMD_WAIT_CYCLES  (P_CMD),
      .CLEAR_WAIT_CYCLES(P_CLR)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_rs      (req_rs),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .init_done   (init_done),
      .busy        (busy),
      .lcd_data_bus(lcd_data_bus),
      .lcd_rs      (lcd_rs),
      .lcd_rw      (lcd_rw),
      .lcd_e       (lcd_e)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Bus observer: pulse count, bus stability while lcd_e is high, rw stuck at 0.
   always @(negedge clk) begin
      if (lcd_rw !== 1'b0) rw_viol++;
      if (!reset) begin
         if (lcd_e === 1'b1 && prev_e === 1'b0) pulses++;
         if (lcd_e === 1'b1 && prev_e === 1'b1 &&
             (lcd_data_bus !== prev_bus || lcd_rs !== prev_rs)) stab_viol++;
      end
      prev_e   = lcd_e;
      prev_bus = lcd_data_bus;
      prev_rs  = lcd_rs;
   end

   // Starts on the negedge where reset has just been released.
   task automatic run_init(input string tag);
      int n;
      int h;
      int w;
      bit rdy_seen;
      logic [7:0] ib [4];
      int expw [4];
      ib[0] = 8'h38; ib[1] = 8'h0C; ib[2] = 8'h06; ib[3] = 8'h01;
      // gap after a mid-sequence pulse includes the next byte's setup
      expw[0] = P_CMD + P_SET; expw[1] = P_CMD + P_SET; expw[2] = P_CMD + P_SET;
      expw[3] = P_CLR;
      n = 0;
      rdy_seen = 0;
      do begin
         @(negedge clk);
         n++;
         if (req_ready) rdy_seen = 1;
      end while (!lcd_e && n < 200);
      chk({tag, "_powerup_to_e"}, n, P_PWR + P_SET);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("%s_byte%0d", tag, i), lcd_data_bus, ib[i]);
         chk($sformatf("%s_rs%0d", tag, i), lcd_rs, 0);
         h = 0;
         while (lcd_e && h < 50) begin
            h++;
            @(negedge clk);
            if (req_ready) rdy_seen = 1;
         end
         chk($sformatf("%s_high%0d", tag, i), h, P_PUL);
         w = 0;
         while (!lcd_e && busy && w < 200) begin
            w++;
            @(negedge clk);
            if (req_ready) rdy_seen = 1;
         end
         chk($sformatf("%s_wait%0d", tag, i), w, expw[i]);
      end
      chk({tag, "_ready_during_init"}, rdy_seen, 0);
      chk({tag, "_init_done"}, init_done, 1);
      chk({tag, "_busy_idle"}, busy, 0);
      @(negedge clk);
      chk({tag, "_ready"}, req_ready, 1);
   endtask

   // Holds the request until ready, returns on the negedge after the accept edge.
   task automatic send(input logic rs, input logic [7:0] data, input bit keep_valid);
      int n;
      req_rs    = rs;
      req_data  = data;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 500) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      if (!keep_valid) req_valid = 1'b0;
   endtask

   // Measures one transfer starting on the negedge after its accept edge.
   task automatic xfer(output int su, output int hi, output int wt, output int lat,
                       output logic [7:0] bus, output logic rs);
      lat = 0; su = 0; hi = 0; wt = 0;
      bus = lcd_data_bus;
      rs  = lcd_rs;
      while (!lcd_e && busy && lat < 100) begin su++; lat++; @(negedge clk); end
      while (lcd_e && lat < 100) begin hi++; lat++; @(negedge clk); end
      while (!lcd_e && busy && lat < 100) begin wt++; lat++; @(negedge clk); end
      while (!req_ready && lat < 100) begin lat++; @(negedge clk); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int su, hi, wt, lat, p0, n;
      logic [7:0] bus;
      logic rs;
      logic [7:0] b2b [3];
      b2b[0] = 8'h48; b2b[1] = 8'h65; b2b[2] = 8'h6C;

      reset     = 1'b1;
      req_valid = 1'b1;
      req_rs    = 1'b1;
      req_data  = 8'h41;
      repeat (3) @(negedge clk);
      chk("rst_e", lcd_e, 0);
      chk("rst_bus", lcd_data_bus, 8'h00);
      chk("rst_rs", lcd_rs, 0);
      chk("rst_rw", lcd_rw, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_busy", busy, 1);
      reset = 1'b0;

      // Init with a request held from reset; it must not be taken early.
      run_init("init1");
      chk("held_not_taken_bus", lcd_data_bus, 8'h01);
      p0 = pulses;
      @(negedge clk);
      req_data  = 8'hFF;
      req_valid = 1'b0;
      xfer(su, hi, wt, lat, bus, rs);
      chk("a41_bus", bus, 8'h41);
      chk("a41_rs", rs, 1);
      chk("a41_setup", su, P_SET);
      chk("a41_high", hi, P_PUL);
      chk("a41_wait", wt, P_CMD);
      chk("a41_latency", lat, P_SET + P_PUL + P_CMD + 1);
      repeat (3) @(negedge clk);
      chk("a41_bus_held", lcd_data_bus, 8'h41);
      chk("a41_rs_held", lcd_rs, 1);
      chk("a41_busy_after", busy, 0);
      chk("a41_ready_after", req_ready, 1);
      chk("a41_one_pulse", pulses - p0, 1);

      send(1'b0, 8'h01, 1'b0);
      xfer(su, hi, wt, lat, bus, rs);
      chk("clr_bus", bus, 8'h01);
      chk("clr_wait", wt, P_CLR);
      chk("clr_latency", lat, P_SET + P_PUL + P_CLR + 1);

      send(1'b0, 8'h80, 1'b0);
      xfer(su, hi, wt, lat, bus, rs);
      chk("c80_bus", bus, 8'h80);
      chk("c80_wait", wt, P_CMD);

      send(1'b1, 8'h01, 1'b0);
      xfer(su, hi, wt, lat, bus, rs);
      chk("d01_rs", rs, 1);
      chk("d01_wait", wt, P_CMD);
      chk("d01_high", hi, P_PUL);

      // Back-to-back with valid held throughout.
      p0 = pulses;
      send(1'b1, b2b[0], 1'b1);
      for (int i = 0; i < 3; i++) begin
         if (i < 2) req_data = b2b[i+1];
         else req_valid = 1'b0;
         xfer(su, hi, wt, lat, bus, rs);
         chk($sformatf("b2b%0d_bus", i), bus, b2b[i]);
         chk($sformatf("b2b%0d_wait", i), wt, P_CMD);
         chk($sformatf("b2b%0d_latency", i), lat, P_SET + P_PUL + P_CMD + 1);
         if (i < 2) @(negedge clk);
      end
      repeat (4) @(negedge clk);
      chk("b2b_pulses", pulses - p0, 3);
      chk("b2b_busy", busy, 0);

      // Reset in the middle of an enable pulse.
      send(1'b0, 8'h0C, 1'b0);
      n = 0;
      while (!lcd_e && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("pre_rst_e", lcd_e, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("midrst_e", lcd_e, 0);
      chk("midrst_init_done", init_done, 0);
      chk("midrst_ready", req_ready, 0);
      chk("midrst_busy", busy, 1);
      reset = 1'b0;
      run_init("init2");

      chk("bus_stable_while_e", stab_viol, 0);
      chk("rw_always_0", rw_viol, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/lcd_sequencer.md
Name: lcd_sequencer

Overview:
- Owns all HD44780-style LCD bus timing, so the control unit no longer pulses lcd_e from its own FSM.
- After reset it runs the fixed power-up/init sequence: 0x38 function set, 0x0C display on, 0x06 entry mode, 0x01 clear.
- It then accepts single command/data byte requests from the control unit over a valid/ready handshake.
- For each byte it generates the setup, enable pulse and execution wait, then returns to ready.

Parameters:
- POWERUP_CYCLES, 750000: idle wait after reset before the first init byte (15 ms at 50 MHz).
- SETUP_CYCLES, 2: cycles data/rs are stable before lcd_e rises. Must be ≥1.
- PULSE_CYCLES, 25: cycles lcd_e is held high. Must be ≥1.
- CMD_WAIT_CYCLES, 2500: wait after lcd_e falls, normal command or data byte (50 us).
- CLEAR_WAIT_CYCLES, 82000: wait after lcd_e falls for clear/home commands (1.64 ms).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  control unit presents a byte
- req_rs  in  1  0 = command, 1 = character data
- req_data  in  8  byte to send
- req_ready  out  1  sequencer can accept a byte this cycle
- init_done  out  1  init sequence complete; stays high until reset
- busy  out  1  high whenever not in IDLE
- lcd_data_bus  out  8  LCD data pins
- lcd_rs  out  1  LCD register select
- lcd_rw  out  1  LCD read/write; constant 0 (write only)
- lcd_e  out  1  LCD enable strobe

Behaviour:
- Reset (sampled on posedge clk while reset = 1):
  - All outputs 0, except busy = 1.
  - State POWERUP, counter 0, init index 0.
  - Reset asserted mid-transfer aborts immediately: lcd_e drops on the next edge and init restarts from POWERUP.
- Single 20-bit down-counter. Every parameter must be < 2^20.
- States: POWERUP, INIT_SETUP, INIT_PULSE, INIT_WAIT, IDLE, SETUP, PULSE, WAIT.
- POWERUP:
  - Counts POWERUP_CYCLES.
  - Then loads init byte[idx] onto lcd_data_bus with rs = 0 and goes to INIT_SETUP.
- INIT_SETUP → INIT_PULSE → INIT_WAIT:
  - Same timing as SETUP/PULSE/WAIT below.
  - Wait length is CLEAR_WAIT_CYCLES for idx 3 (0x01), otherwise CMD_WAIT_CYCLES.
  - After INIT_WAIT: if idx < 3, idx++ and go to INIT_SETUP with the next byte.
  - If idx = 3: init_done ← 1, go to IDLE.
- IDLE:
  - req_ready = 1 (registered, high only in IDLE with init_done = 1).
  - Transfer occurs on an edge where req_valid & req_ready.
  - At that edge, req_data → lcd_data_bus and req_rs → lcd_rs; req_ready ← 0; go to SETUP.
  - req_valid with req_ready = 0 is ignored. Requester holds valid and data until accepted.
  - Requests during init are never accepted; req_ready stays 0.
- SETUP: lcd_e = 0 for exactly SETUP_CYCLES cycles, then PULSE.
- PULSE: lcd_e = 1 for exactly PULSE_CYCLES cycles, then WAIT.
- WAIT:
  - lcd_e = 0 for W cycles, then IDLE with req_ready = 1.
  - W = CLEAR_WAIT_CYCLES when rs = 0 and byte ∈ {0x01, 0x02, 0x03}; else CMD_WAIT_CYCLES.
- Bus hold: lcd_data_bus and lcd_rs hold their values through SETUP/PULSE/WAIT and keep the last byte in IDLE. They never change while lcd_e = 1.
- Latency: accept edge to req_ready high = SETUP_CYCLES + PULSE_CYCLES + W + 1 cycles. One byte in flight at a time; no queue.
- busy = 1 in every state except IDLE.
- lcd_rw is always 0.
- Control unit mapping:
  - DISPLAY sends rs = 1, byte = register[7:0].
  - CLEAR sends rs = 0, byte = 0x01.
- All outputs are registered, with no combinational path from req_* to outputs.

Test Plan (params POWERUP=10, SETUP=2, PULSE=3, CMD_WAIT=5, CLEAR_WAIT=20):
- Release reset, req_valid = 0 → 10 idle cycles, then bytes 0x38, 0x0C, 0x06, 0x01 with rs = 0.
  - Each byte gives exactly 3 cycles of lcd_e high.
  - Waits after lcd_e falls: 5, 5, 5, 20.
  - Then init_done = 1, req_ready = 1, busy = 0.
- Hold req_valid = 1 (rs = 1, 0x41) from reset → not accepted before init_done.
  - Accepted on the first ready edge.
  - lcd_rs = 1 and lcd_data_bus = 0x41 throughout a 3-cycle lcd_e pulse.
  - req_ready returns 11 cycles after acceptance (2 + 3 + 5 + 1).
- After init, send cmd 0x01 → wait after lcd_e falls is 20 cycles.
  - Follow with cmd 0x80 → wait is 5 cycles.
  - Follow with rs = 1, 0x01 → wait is 5 cycles (data is not treated as clear).
- Change req_data to 0xFF while busy → lcd_data_bus remains the accepted byte until the next acceptance.
  - At most one acceptance per req_ready window.
- Assert reset for 1 cycle in the middle of PULSE → next cycle lcd_e = 0, init_done = 0, req_ready = 0.
  - The full init sequence repeats.
- Back-to-back: keep req_valid high for 3 distinct bytes → exactly 3 lcd_e pulses.
  - Pulses occur in order, each separated by the required wait; no byte is lost or duplicated.
